// File: rtl/pulse_sched_pkg.sv
// ---------------------------------------------------------------------------
// pulse_sched_pkg
// Shared types and constants for the pulse mode scheduler:
//   state_t        - sequencer states (IDLE, SWITCH, RUN, DONE)
//   MODE_*         - pulse_generator mode encodings
//   DEF_STEPS      - default number of table entries
//   DEF_DUR_W      - default step-duration width in clock cycles
// ---------------------------------------------------------------------------
package pulse_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWITCH = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [1:0] MODE_OFF = 2'd0;
    localparam logic [1:0] MODE_1   = 2'd1;
    localparam logic [1:0] MODE_2   = 2'd2;
    localparam logic [1:0] MODE_3   = 2'd3;

    localparam int DEF_STEPS = 4;
    localparam int DEF_DUR_W = 16;

endpackage

// File: rtl/pulse_sched_table.sv
// ---------------------------------------------------------------------------
// pulse_sched_table
// STEPS x (mode, duration) register file for the scheduler.
//   clk, rst_n   - clock, asynchronous active-low reset (clears every entry)
//   wr_en        - write strobe
//   wr_addr      - entry to write
//   wr_mode      - mode value written
//   wr_dur       - duration written (0 = entry is skipped during playback)
//   rd_addr      - entry to read (combinational read port)
//   rd_mode      - mode of entry rd_addr
//   rd_dur       - duration of entry rd_addr
//   any_nonzero  - high when at least one entry has a non-zero duration
// A write lands at the clock edge, so a same-cycle read returns the old value.
// ---------------------------------------------------------------------------
module pulse_sched_table
    import pulse_sched_pkg::*;
#(
    parameter int STEPS = DEF_STEPS,
    parameter int DUR_W = DEF_DUR_W,
    parameter int IDX_W = $clog2(STEPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [1:0]       wr_mode,
    input  logic [DUR_W-1:0] wr_dur,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [1:0]       rd_mode,
    output logic [DUR_W-1:0] rd_dur,
    output logic             any_nonzero
);

    logic [1:0]       mode_mem [STEPS];
    logic [DUR_W-1:0] dur_mem  [STEPS];

    // NOTE: this table is small and must read as all-zero after reset (an
    // all-zero table makes start a no-op), so every entry is reset here rather
    // than left uninitialised like a RAM macro would be.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STEPS; i++) begin
                mode_mem[i] <= MODE_OFF;
                dur_mem[i]  <= '0;
            end
        end else if (wr_en) begin
            mode_mem[wr_addr] <= wr_mode;
            dur_mem[wr_addr]  <= wr_dur;
        end
    end

    assign rd_mode = mode_mem[rd_addr];
    assign rd_dur  = dur_mem[rd_addr];

    // NOTE: combinational outputs get a default before any conditional update
    // so no path leaves them unassigned and no latch is inferred.
    always_comb begin
        any_nonzero = 1'b0;
        for (int i = 0; i < STEPS; i++) begin
            if (dur_mem[i] != '0) begin
                any_nonzero = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pulse_mode_scheduler.sv
// ---------------------------------------------------------------------------
// pulse_mode_scheduler
// Plays a table of (mode, duration) steps into a pulse_generator, pulsing the
// generator reset for one cycle (SWITCH) before each step's RUN cycles.
//   clk, rst_n             - clock, asynchronous active-low reset
//   cfg_we/addr/mode/dur   - table write port, accepted in every state
//   start                  - begin playback (honoured in IDLE only)
//   stop                   - abort playback (stop beats start in IDLE)
//   loop                   - captured at accepted start; 1 = wrap to entry 0
//   gen_mode               - pulse_generator.mode
//   gen_rst                - pulse_generator.rst (active-high)
//   busy                   - high in SWITCH and RUN
//   step_idx               - table entry currently loaded
//   done                   - one-cycle pulse when one-shot playback completes
// All outputs decode registered state only.
// ---------------------------------------------------------------------------
module pulse_mode_scheduler
    import pulse_sched_pkg::*;
#(
    parameter int STEPS = DEF_STEPS,
    parameter int DUR_W = DEF_DUR_W,
    parameter int IDX_W = $clog2(STEPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [1:0]       cfg_mode,
    input  logic [DUR_W-1:0] cfg_dur,
    input  logic             start,
    input  logic             stop,
    input  logic             loop,
    output logic [1:0]       gen_mode,
    output logic             gen_rst,
    output logic             busy,
    output logic [IDX_W-1:0] step_idx,
    output logic             done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STEPS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [DUR_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             loop_q, loop_d;
    logic             advance;

    logic [1:0]       rd_mode;
    logic [DUR_W-1:0] rd_dur;
    logic             any_nonzero;

    pulse_sched_table #(
        .STEPS (STEPS),
        .DUR_W (DUR_W),
        .IDX_W (IDX_W)
    ) u_table (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (cfg_we),
        .wr_addr     (cfg_addr),
        .wr_mode     (cfg_mode),
        .wr_dur      (cfg_dur),
        .rd_addr     (idx_q),
        .rd_mode     (rd_mode),
        .rd_dur      (rd_dur),
        .any_nonzero (any_nonzero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_OFF;
            loop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            loop_q  <= loop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        loop_d  = loop_q;
        advance = 1'b0;

        case (state_q)
            IDLE: begin
                idx_d = '0;
                // An all-zero table has nothing to play, so start is ignored.
                if (start && !stop && any_nonzero) begin
                    state_d = SWITCH;
                    loop_d  = loop;
                end
            end
            SWITCH: begin
                mode_d = rd_mode;
                if (rd_dur != '0) begin
                    // The RUN state runs while the counter counts dur-1 .. 0,
                    // which gives exactly dur RUN cycles.
                    cnt_d   = rd_dur - DUR_W'(1);
                    state_d = RUN;
                end else begin
                    advance = 1'b1;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q - DUR_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase

        if (advance) begin
            if (idx_q != LAST_IDX) begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = SWITCH;
            end else if (loop_q) begin
                idx_d   = '0;
                state_d = SWITCH;
            end else begin
                state_d = DONE;
            end
        end

        // Abort overrides whatever the active states decided above.
        if (stop && state_q != IDLE) begin
            state_d = IDLE;
            idx_d   = '0;
        end
    end

    always_comb begin
        gen_rst  = (state_q != RUN);
        busy     = (state_q == SWITCH) || (state_q == RUN);
        done     = (state_q == DONE);
        step_idx = idx_q;
        case (state_q)
            SWITCH:  gen_mode = rd_mode;
            RUN:     gen_mode = mode_q;
            default: gen_mode = MODE_OFF;
        endcase
    end

endmodule

// File: tb/tb_pulse_mode_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pulse_mode_scheduler
// Scoreboard bench. The stimulus process drives one input vector per cycle and
// a step-level reference model pushes the expected output tuple for that
// cycle; a monitor pops and compares on every falling edge.
// ---------------------------------------------------------------------------
module tb_pulse_mode_scheduler;

    localparam int STEPS = 4;
    localparam int DUR_W = 16;
    localparam int IDX_W = 2;

    typedef struct packed {
        logic [1:0]       mode;
        logic             rst;
        logic             busy;
        logic [IDX_W-1:0] idx;
        logic             done;
    } obs_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_we;
    logic [IDX_W-1:0] cfg_addr;
    logic [1:0]       cfg_mode;
    logic [DUR_W-1:0] cfg_dur;
    logic             start;
    logic             stop;
    logic             loop;
    logic [1:0]       gen_mode;
    logic             gen_rst;
    logic             busy;
    logic [IDX_W-1:0] step_idx;
    logic             done;

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    // Reference model: table contents plus the not-yet-played cycles of the
    // current step, expanded from (mode, duration) when the step is loaded.
    logic [1:0] m_mode [STEPS];
    int         m_dur  [STEPS];
    obs_t       plan [$];
    obs_t       sb   [$];
    bit         playing;
    int         next_idx;
    bit         loop_cap;

    pulse_mode_scheduler #(
        .STEPS (STEPS),
        .DUR_W (DUR_W),
        .IDX_W (IDX_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_mode (cfg_mode),
        .cfg_dur  (cfg_dur),
        .start    (start),
        .stop     (stop),
        .loop     (loop),
        .gen_mode (gen_mode),
        .gen_rst  (gen_rst),
        .busy     (busy),
        .step_idx (step_idx),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input int mode, input bit r, input bit b, input int idx, input bit d);
        obs_t o;
        o.mode = mode[1:0];
        o.rst  = r;
        o.busy = b;
        o.idx  = idx[IDX_W-1:0];
        o.done = d;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.mode = gen_mode;
        o.rst  = gen_rst;
        o.busy = busy;
        o.idx  = step_idx;
        o.done = done;
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got mode=%0d rst=%0b busy=%0b idx=%0d done=%0b, expected mode=%0d rst=%0b busy=%0b idx=%0d done=%0b",
                     name, $time, act.mode, act.rst, act.busy, act.idx, act.done,
                     exp.mode, exp.rst, exp.busy, exp.idx, exp.done);
        end
    endtask

    function automatic bit any_nz();
        for (int i = 0; i < STEPS; i++) begin
            if (m_dur[i] != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < STEPS; i++) begin
            m_mode[i] = 2'd0;
            m_dur[i]  = 0;
        end
        plan.delete();
        sb.delete();
        playing  = 1'b0;
        next_idx = 0;
        loop_cap = 1'b0;
    endtask

    // One step = one reset cycle in the step's mode, then dur cycles running.
    task automatic load_entry();
        int k = next_idx;
        plan.push_back(mk(m_mode[k], 1'b1, 1'b1, k, 1'b0));
        for (int c = 0; c < m_dur[k]; c++) begin
            plan.push_back(mk(m_mode[k], 1'b0, 1'b1, k, 1'b0));
        end
        if (k < STEPS - 1) begin
            next_idx = k + 1;
        end else if (loop_cap) begin
            next_idx = 0;
        end else begin
            plan.push_back(mk(0, 1'b1, 1'b0, STEPS - 1, 1'b1));
            playing = 1'b0;
        end
    endtask

    task automatic model_cycle(input bit we, input int addr, input int mode, input int dur,
                               input bit st, input bit sp, input bit lp);
        obs_t cur;
        if (plan.size() == 0 && playing) load_entry();
        if (plan.size() != 0) cur = plan.pop_front();
        else                  cur = mk(0, 1'b1, 1'b0, 0, 1'b0);
        sb.push_back(cur);
        if (sp && (cur.busy || cur.done)) begin
            plan.delete();
            playing = 1'b0;
        end else if (!cur.busy && !cur.done && st && !sp && any_nz()) begin
            playing  = 1'b1;
            next_idx = 0;
            loop_cap = lp;
        end
        // Writes land at the end of this cycle, after any load above.
        if (we) begin
            m_mode[addr] = mode[1:0];
            m_dur[addr]  = dur;
        end
    endtask

    task automatic drive_cycle(input bit we, input int addr, input int mode, input int dur,
                               input bit st, input bit sp, input bit lp);
        @(posedge clk);
        #1;
        cfg_we   = we;
        cfg_addr = addr[IDX_W-1:0];
        cfg_mode = mode[1:0];
        cfg_dur  = dur[DUR_W-1:0];
        start    = st;
        stop     = sp;
        loop     = lp;
        model_cycle(we, addr, mode, dur, st, sp, lp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wr(input int a, input int m, input int d);
        drive_cycle(1'b1, a, m, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic go(input bit lp);
        drive_cycle(1'b0, 0, 0, 0, 1'b1, 1'b0, lp);
    endtask

    always @(negedge clk) begin
        if (mon_en && sb.size() != 0) begin
            check("cycle_outputs", sample(), sb.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_mode = '0; cfg_dur = '0;
        start = 1'b0; stop = 1'b0; loop = 1'b0;
        model_reset();
        #12;
        check("reset_outputs", sample(), mk(0, 1'b1, 1'b0, 0, 1'b0));
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // All-zero table: start is ignored.
        go(1'b0);
        idle(3);

        // One-shot playback of the reference table.
        wr(0, 1, 3); wr(1, 2, 2); wr(2, 3, 0); wr(3, 0, 1);
        go(1'b0);
        idle(14);

        // Looped playback, aborted during the second pass's entry 1 RUN.
        go(1'b1);
        idle(15);
        drive_cycle(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        idle(4);

        // start together with stop in IDLE: nothing happens.
        drive_cycle(1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
        idle(3);

        // start while busy is ignored.
        go(1'b0);
        idle(4);
        go(1'b1);
        idle(10);

        // Rewrite entry 1 while entry 0 runs.
        wr(0, 1, 5); wr(1, 0, 0); wr(2, 0, 0); wr(3, 0, 0);
        go(1'b0);
        idle(2);
        wr(1, 3, 2);
        idle(12);

        // Randomised phase.
        for (int i = 0; i < 800; i++) begin
            drive_cycle(($urandom_range(0, 3) == 0), $urandom_range(0, STEPS - 1),
                        $urandom_range(0, 3), $urandom_range(0, 6),
                        ($urandom_range(0, 5) == 0), ($urandom_range(0, 39) == 0),
                        $urandom_range(0, 1));
        end
        drive_cycle(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Asynchronous reset in the middle of a RUN.
        wr(0, 2, 8);
        go(1'b0);
        idle(3);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("async_reset", sample(), mk(0, 1'b1, 1'b0, 0, 1'b0));
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;
        go(1'b1);
        idle(4);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pulse_mode_scheduler.md
# pulse_mode_scheduler

Programmable sequencer that drives the `mode` and reset inputs of `pulse_generator`. It holds a small table of (mode, duration) steps and plays them in order, pulsing the generator's reset for one cycle between steps so each new mode starts from a clean PWM period. It supports one-shot or looped playback and sits between the control/register logic and the single `pulse_generator` instance.

## Interface
- `STEPS`, 4: number of table entries. Power of two, ≥2.
- `DUR_W`, 16: width of a step duration, in clock cycles.
- `IDX_W`, $clog2(STEPS): table index width (derived).

- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `cfg_we`  in  1  table write strobe.
- `cfg_addr`  in  IDX_W  table entry to write.
- `cfg_mode`  in  2  mode value for the entry.
- `cfg_dur`  in  DUR_W  duration for the entry, in cycles; 0 = skip the entry.
- `start`  in  1  begin playback; sampled in IDLE only.
- `stop`  in  1  abort playback; sampled in every state.
- `loop`  in  1  captured at accepted `start`; 1 = restart at entry 0 after the last entry.
- `gen_mode`  out  2  to `pulse_generator.mode`.
- `gen_rst`  out  1  to `pulse_generator.rst` (active-high).
- `busy`  out  1  high in SWITCH and RUN.
- `step_idx`  out  IDX_W  entry currently loaded.
- `done`  out  1  one-cycle pulse when one-shot playback completes.

## Operation
- States:
  - IDLE: `gen_rst`=1, `gen_mode`=0, `busy`=0.
  - SWITCH: load entry `step_idx`; `gen_rst`=1, `gen_mode`=entry mode, `busy`=1.
  - RUN: `gen_rst`=0, `gen_mode`=held mode, `busy`=1.
  - DONE: `done`=1, `gen_rst`=1, `gen_mode`=0.
- IDLE → SWITCH on `start`=1 && `stop`=0 && at least one entry has dur≠0. Set `step_idx`=0 and capture `loop`. Otherwise stay in IDLE; with all durations 0, `start` is ignored.
- SWITCH:
  - If dur≠0: down-counter ← dur−1, go to RUN.
  - If dur=0: go to the next entry. The state stays SWITCH; each skipped entry costs one cycle.
- RUN: decrement each cycle. When the counter is 0, go to the next entry.
- Next entry:
  - If `step_idx`<STEPS−1: `step_idx`+1, go to SWITCH.
  - If it is the last entry and loop is captured: `step_idx`←0, go to SWITCH.
  - Otherwise: go to DONE.
- DONE → IDLE unconditionally. `step_idx` resets to 0 on entry to IDLE.
- `stop`=1 in SWITCH, RUN or DONE → IDLE next cycle, with no `done` pulse. If `stop` and `start` are high together in IDLE, `stop` wins.
- Table writes are accepted in every state and take effect at the next SWITCH that loads that entry. The running counter is unaffected.
- If `cfg_we` writes the entry being loaded in the same cycle, SWITCH loads the old value.
- Durations are unsigned; the counter is DUR_W bits and never wraps.

## Timing
- Reset (`rst_n`=0, async): state=IDLE, table entries all (mode 0, dur 0), counter 0, captured loop 0.
- Output reset values: `gen_mode`=0, `gen_rst`=1, `busy`=0, `step_idx`=0, `done`=0.
- All outputs are registered or decoded from registered state only. No input→output combinational path.
- `start` sampled high at edge N → SWITCH during cycle N+1. An entry with dur d then gives exactly d RUN cycles.
- Entry period = 1 + d cycles (0-duration entry = 1 cycle).
- One-shot total, from first SWITCH to the last RUN cycle = Σ(1+d_k). DONE follows immediately; IDLE is the cycle after DONE.
- `rst_n` deassertion mid-playback is not special-cased: the block is in IDLE after reset regardless of prior state.

## Structure
- Shared package `pulse_sched_pkg`:
  - state enum {IDLE, SWITCH, RUN, DONE}
  - mode constants MODE_OFF=2'd0 … MODE_3=2'd3
  - default STEPS/DUR_W
- Sub-module `pulse_sched_table`: STEPS×(2+DUR_W) register file with write port, one combinational read port at `step_idx`, and an `any_nonzero` flag.
- The FSM, counter and output decode stay in the top level.

## Test plan
- Program {(1,3),(2,2),(3,0),(0,1)}, loop=0, pulse `start`:
  - gen_mode/gen_rst per cycle: 1/1, 1/0×3, 2/1, 2/0×2, 3/1, 0/1, 0/0×1; then DONE with `done`=1 one cycle; `busy` high for exactly 10 cycles.
- Same table, loop=1: after the (0,1) entry, `step_idx` returns to 0 and the SWITCH with mode 1 recurs at cycle 11. Assert `stop` in the second pass's RUN of entry 1 → IDLE next cycle, `done` never asserted.
- All durations 0, pulse `start` → remains IDLE, `busy`=0, `gen_rst`=1 throughout.
- `start` and `stop` high together in IDLE → no state change. `start` while `busy` → ignored, sequence timing unchanged.
- During RUN of entry 0 (dur 5), write entry 1 to (3,2) → entry 0 still runs 5 cycles; entry 1 plays mode 3 for 2 cycles.
- Drop `rst_n` asynchronously mid-RUN → outputs immediately `gen_mode`=0, `gen_rst`=1, `busy`=0, `step_idx`=0. Table reads all zero afterwards, so `start` is ignored.
